mux_arb_0: RTL and testbench

MUX_ARB_0 -- requirements
Module: mux_arb_0

---
 rtl/mux_arb_0.sv | 138 +++++++++++++
 tb/tb_mux_arb_0.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_arb_0.sv
// Four-requester round-robin arbiter with a hold-time limit, driving a shared
// WIDTH-bit bus from the data port of the current owner.
module mux_arb_0 #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [1:0]       sel_r, sel_s;
  logic [7:0]       hcnt_r, hcnt_s;
  logic [3:0]       gnt_r, gnt_s;
  logic             valid_r, valid_s;
  logic [1:0]       win_s;
  logic [1:0]       idx_s;
  logic             found_s;
  logic             others_s;
  logic [WIDTH-1:0] out_s;

  // Round-robin winner search starting at the pointer position
  always_comb begin
    win_s   = 2'd0;
    idx_s   = 2'd0;
    found_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_r + 2'(k);
      if (!found_s && req[idx_s]) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Some requester other than the current owner is waiting
  always_comb begin
    others_s = |(req & ~(4'b0001 << sel_r));
  end

  // Next-state logic: grant from idle, hold/saturate, or release/preempt
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    hcnt_s  = hcnt_r;
    gnt_s   = gnt_r;
    valid_s = valid_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          state_s = BUSY;
          gnt_s   = 4'b0001 << win_s;
          sel_s   = win_s;
          valid_s = 1'b1;
          hcnt_s  = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // a drop and a timeout in the same cycle collapse into one release
        if (!req[sel_r] || (others_s && (hcnt_r == HOLD_LAST))) begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          valid_s = 1'b0;
          ptr_s   = sel_r + 2'd1;
        end else if (hcnt_r != HOLD_LAST) begin
          hcnt_s = hcnt_r + 8'd1;
        end else begin
          hcnt_s = hcnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      hcnt_r  <= 8'd0;
      gnt_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      hcnt_r  <= hcnt_s;
      gnt_r   <= gnt_s;
      valid_r <= valid_s;
    end
  end

  // Shared bus mux, forced to zero when no grant is active
  always_comb begin
    out_s = '0;
    if (valid_r) begin
      case (sel_r)
        2'd0:    out_s = d0;
        2'd1:    out_s = d1;
        2'd2:    out_s = d2;
        2'd3:    out_s = d3;
        default: out_s = '0;
      endcase
    end else begin
      out_s = '0;
    end
  end

  assign gnt   = gnt_r;
  assign sel   = sel_r;
  assign valid = valid_r;
  assign out   = out_s;

endmodule

// File: tb/tb_mux_arb_0.sv
// Self-checking bench for mux_arb_0: vector table plus multi-cycle sequences
// for hold limit, saturation, wrap and asynchronous reset.
module tb_mux_arb_0;
  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] out;

  mux_arb_0 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .valid(valid), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  typedef struct {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] out;
    int               tag;
  } exp_t;

  exp_t             exp_q[$];
  vec_t             tbl[14];
  logic [WIDTH-1:0] dval[4];
  int               n_chk  = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, want);
    end
  endtask

  // Drive one cycle of req, queue the expectation, compare after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                      input logic ev, input int tag);
    exp_t e;
    req     = r;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = ev;
    e.out   = ev ? dval[es] : '0;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("gnt",   e.tag, 32'(gnt),   32'(e.gnt));
    chk("sel",   e.tag, 32'(sel),   32'(e.sel));
    chk("valid", e.tag, 32'(valid), 32'(e.valid));
    chk("out",   e.tag, 32'(out),   32'(e.out));
  endtask

  // Per-cycle invariants: grant one-hot-or-zero, valid mirrors grant
  always @(negedge clk) begin
    chk("onehot0", -1, 32'($onehot0(gnt)), 32'd1);
    chk("valid_eq_or_gnt", -1, 32'(valid), 32'(|gnt));
  end

  initial begin
    #200000;
    $display("FAIL watchdog tag=0 actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] eg;
    logic [1:0] es;
    logic       ev;

    d0 = 16'hA000; d1 = 16'h1111; d2 = 16'h2222; d3 = 16'h3333;
    dval[0] = d0; dval[1] = d1; dval[2] = d2; dval[3] = d3;

    tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[1]  = '{4'b1000, 4'b0000, 2'd1, 1'b0};
    tbl[2]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[3]  = '{4'b1110, 4'b1000, 2'd3, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    tbl[6]  = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0000, 2'd1, 1'b0};
    tbl[8]  = '{4'b0101, 4'b0100, 2'd2, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0000, 2'd2, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 2'd3, 1'b0};
    tbl[12] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    rst = 1'b1;
    req = 4'b0000;
    #3;
    chk("rst_gnt",   0, 32'(gnt),   32'd0);
    chk("rst_sel",   0, 32'(sel),   32'd0);
    chk("rst_valid", 0, 32'(valid), 32'd0);
    chk("rst_out",   0, 32'(out),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      step(tbl[i].req, tbl[i].gnt, tbl[i].sel, tbl[i].valid, i);

    // Hold limit with two constant requesters, starting from a fresh pointer
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 26; c++) begin
      ev = !((c == 8) || (c == 17));
      if (c < 8)       eg = 4'b0001;
      else if (c == 8) eg = 4'b0000;
      else if (c < 17) eg = 4'b0010;
      else if (c == 17) eg = 4'b0000;
      else             eg = 4'b0001;
      es = (c <= 8) ? 2'd0 : ((c <= 17) ? 2'd1 : 2'd0);
      step(4'b0011, eg, es, ev, 100 + c);
    end
    // Owner drops exactly at timeout: pointer must advance only once
    step(4'b0010, 4'b0000, 2'd0, 1'b0, 126);
    step(4'b1010, 4'b0010, 2'd1, 1'b1, 127);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 128);

    // Sole requester holds far past the limit; counter must saturate
    for (int c = 0; c < 20; c++)
      step(4'b0100, 4'b0100, 2'd2, 1'b1, 200 + c);
    step(4'b0110, 4'b0000, 2'd2, 1'b0, 220);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 221);

    // Asynchronous reset between edges while requester 2 owns the bus
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt",   222, 32'(gnt),   32'd0);
    chk("arst_valid", 222, 32'(valid), 32'd0);
    chk("arst_out",   222, 32'(out),   32'd0);
    chk("arst_sel",   222, 32'(sel),   32'd0);
    #1 rst = 1'b0;
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 230);
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 231);

    chk("queue_empty", 232, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
